// File: rtl/pll_reconf_pkg.sv
// Shared types and constants for the HDMI PLL reconfiguration sequencer.
//   state_e    : sequencer state encoding
//   MODE_*     : video mode codes understood by the scan-chain ROM
//   MODE_COUNT : number of defined mode codes (default for NUM_MODES)
//   max3       : helper used to size the shared wait counter
package pll_reconf_pkg;

   localparam int unsigned MODE_COUNT = 4;

   localparam logic [7:0] MODE_1080P = 8'd0;
   localparam logic [7:0] MODE_960P  = 8'd1;
   localparam logic [7:0] MODE_480P  = 8'd2;
   localparam logic [7:0] MODE_VGA   = 8'd3;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LOAD        = 3'd1,
      ST_WAIT_LOAD   = 3'd2,
      ST_RECONF      = 3'd3,
      ST_WAIT_RECONF = 3'd4,
      ST_WAIT_LOCK   = 3'd5,
      ST_SETTLE      = 3'd6
   } state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_wait_timer.sv
// Up-counter shared by the busy-wait, lock-wait and settle phases.
//   clock, reset_n : clock / async active-low reset
//   clear_i        : restart from zero (priority over en_i)
//   en_i           : count this cycle
//   limit_i        : terminal value for the current phase
//   count_o        : current count (registered)
//   tc_c           : combinational, count_o == limit_i
module pll_wait_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_c
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_c    = (count_q == limit_i);

endmodule

// File: rtl/pll_reconf_sequencer.sv
// Sequences HDMI PLL reconfiguration on a video-mode change and holds the
// downstream video pipeline in reset until the new clock has settled.
//   req_valid/req_mode/req_ready : mode-request FIFO read side (show-ahead)
//   mode_sel/write_from_rom/reconfig/reconf_busy : ROM image + altpll_reconfig
//   pll_locked   : HDMI PLL lock, already synchronised to clock
//   video_reset  : downstream video reset
//   current_mode : last applied mode; seq_busy : not idle
//   done/bad_mode: one-cycle completion pulses; error : sticky failure flag
module pll_reconf_sequencer #(
   parameter int unsigned NUM_MODES     = pll_reconf_pkg::MODE_COUNT,
   parameter int unsigned BUSY_TIMEOUT  = 4096,
   parameter int unsigned LOCK_TIMEOUT  = 1000000,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [7:0] req_mode,
   output logic       req_ready,
   output logic [1:0] mode_sel,
   output logic       write_from_rom,
   output logic       reconfig,
   input  logic       reconf_busy,
   input  logic       pll_locked,
   output logic       video_reset,
   output logic [7:0] current_mode,
   output logic       seq_busy,
   output logic       done,
   output logic       error,
   output logic       bad_mode
);
   import pll_reconf_pkg::*;

   localparam int unsigned CNT_W  = $clog2(max3(BUSY_TIMEOUT, LOCK_TIMEOUT, SETTLE_CYCLES));
   localparam int unsigned RTRY_W = $clog2(MAX_RETRIES + 1);

   state_e            state_q, state_d;
   logic              boot_q, boot_d;
   logic              locked_q;
   logic              req_ready_q, req_ready_d;
   logic [1:0]        mode_sel_q, mode_sel_d;
   logic              wfr_q, wfr_d;
   logic              reconfig_q, reconfig_d;
   logic              video_reset_q, video_reset_d;
   logic [7:0]        cur_mode_q, cur_mode_d;
   logic [7:0]        target_q, target_d;
   logic              seq_busy_q, seq_busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              bad_mode_q, bad_mode_d;
   logic [RTRY_W-1:0] retry_q, retry_d, retry_inc;

   logic              tmr_clear, tmr_en, tmr_tc;
   logic [CNT_W-1:0]  tmr_limit, tmr_count;
   logic              past_ignore;

   pll_wait_timer #(.CNT_W(CNT_W)) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear_i (tmr_clear),
      .en_i    (tmr_en),
      .limit_i (tmr_limit),
      .count_o (tmr_count),
      .tc_c    (tmr_tc)
   );

   // Terminal count for the phase currently being timed
   always_comb begin
      case (state_q)
         ST_WAIT_LOCK: tmr_limit = CNT_W'(LOCK_TIMEOUT - 1);
         ST_SETTLE:    tmr_limit = CNT_W'(SETTLE_CYCLES - 1);
         default:      tmr_limit = CNT_W'(BUSY_TIMEOUT - 1);
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      boot_d        = boot_q;
      req_ready_d   = 1'b0;
      mode_sel_d    = mode_sel_q;
      video_reset_d = video_reset_q;
      cur_mode_d    = cur_mode_q;
      target_d      = target_q;
      done_d        = 1'b0;
      error_d       = error_q;
      bad_mode_d    = 1'b0;
      retry_d       = retry_q;
      retry_inc     = retry_q + RTRY_W'(1);
      // altpll_reconfig raises busy a cycle or two after a pulse
      past_ignore   = (tmr_count >= CNT_W'(2));

      case (state_q)
         ST_IDLE: begin
            if (boot_q) begin
               // first lock after reset releases video_reset through SETTLE
               boot_d  = 1'b0;
               state_d = ST_WAIT_LOCK;
            end else if (req_ready_q) begin
               // FIFO word is consumed this cycle; decide on it
               error_d = 1'b0;
               if (req_mode >= 8'(NUM_MODES)) begin
                  bad_mode_d = 1'b1;
               end else if ((req_mode == cur_mode_q) && pll_locked) begin
                  done_d = 1'b1;
               end else begin
                  video_reset_d = 1'b1;
                  mode_sel_d    = req_mode[1:0];
                  target_d      = req_mode;
                  retry_d       = '0;
                  state_d       = ST_LOAD;
               end
            end else if (locked_q && !pll_locked) begin
               // lost lock on its own: wait for relock on the current image
               video_reset_d = 1'b1;
               mode_sel_d    = cur_mode_q[1:0];
               target_d      = cur_mode_q;
               state_d       = ST_WAIT_LOCK;
            end else if (req_valid) begin
               req_ready_d = 1'b1;
            end
         end
         ST_LOAD: state_d = ST_WAIT_LOAD;
         ST_WAIT_LOAD: begin
            if (past_ignore && !reconf_busy) begin
               state_d = ST_RECONF;
            end else if (tmr_tc) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RECONF: state_d = ST_WAIT_RECONF;
         ST_WAIT_RECONF: begin
            if (past_ignore && !reconf_busy) begin
               state_d = ST_WAIT_LOCK;
            end else if (tmr_tc) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_LOCK: begin
            if (pll_locked) begin
               state_d = ST_SETTLE;
            end else if (tmr_tc) begin
               retry_d = retry_inc;
               if (retry_inc < RTRY_W'(MAX_RETRIES)) begin
                  state_d = ST_LOAD;
               end else begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SETTLE: begin
            if (!pll_locked) begin
               state_d = ST_WAIT_LOCK;
            end else if (tmr_tc) begin
               video_reset_d = 1'b0;
               cur_mode_d    = target_q;
               done_d        = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // pulses coincide exactly with the one-cycle LOAD / RECONF states
      wfr_d      = (state_d == ST_LOAD);
      reconfig_d = (state_d == ST_RECONF);
      seq_busy_d = (state_d != ST_IDLE);
      tmr_clear  = (state_d != state_q);
      tmr_en     = (state_q != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         boot_q        <= 1'b1;
         locked_q      <= 1'b0;
         req_ready_q   <= 1'b0;
         mode_sel_q    <= 2'd0;
         wfr_q         <= 1'b0;
         reconfig_q    <= 1'b0;
         video_reset_q <= 1'b1;
         cur_mode_q    <= MODE_1080P;
         target_q      <= MODE_1080P;
         seq_busy_q    <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         bad_mode_q    <= 1'b0;
         retry_q       <= '0;
      end else begin
         state_q       <= state_d;
         boot_q        <= boot_d;
         locked_q      <= pll_locked;
         req_ready_q   <= req_ready_d;
         mode_sel_q    <= mode_sel_d;
         wfr_q         <= wfr_d;
         reconfig_q    <= reconfig_d;
         video_reset_q <= video_reset_d;
         cur_mode_q    <= cur_mode_d;
         target_q      <= target_d;
         seq_busy_q    <= seq_busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         bad_mode_q    <= bad_mode_d;
         retry_q       <= retry_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign mode_sel       = mode_sel_q;
   assign write_from_rom = wfr_q;
   assign reconfig       = reconfig_q;
   assign video_reset    = video_reset_q;
   assign current_mode   = cur_mode_q;
   assign seq_busy       = seq_busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign bad_mode       = bad_mode_q;

endmodule

// File: tb/tb_pll_reconf_sequencer.sv
// Self-checking bench for pll_reconf_sequencer: directed scenarios plus
// randomized requests scored against a request-level outcome model.
module tb_pll_reconf_sequencer;

   localparam int unsigned NM = 4;
   localparam int unsigned BT = 64;
   localparam int unsigned LT = 200;
   localparam int unsigned SC = 32;
   localparam int unsigned MR = 3;

   logic       clock, reset_n;
   logic       req_valid, req_ready;
   logic [7:0] req_mode, current_mode;
   logic [1:0] mode_sel;
   logic       write_from_rom, reconfig, reconf_busy, pll_locked;
   logic       video_reset, seq_busy, done, error, bad_mode;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // monitor tallies
   int wfr_cnt = 0, rcf_cnt = 0, done_cnt = 0, bad_cnt = 0, rdy_cnt = 0;
   int vr_rise_cnt = 0, pulse_long = 0, vr_viol = 0, rdy_busy = 0;
   int vr_fall_cyc = 0, lock_rise_cyc = 0;
   logic vr_prev = 1'b1, wfr_prev = 1'b0, rcf_prev = 1'b0;
   logic done_prev = 1'b0, bad_prev = 1'b0, rdy_prev = 1'b0;

   // environment models (busy and lock) and their controls
   int busy_len = 5, lock_delay = 10, drop_tok = 0;
   bit lock_enable = 1'b0;
   int busy_left = 0, lock_left = 0, drop_seen = 0;

   logic [7:0] model_mode = 8'd0;

   pll_reconf_sequencer #(
      .NUM_MODES(NM), .BUSY_TIMEOUT(BT), .LOCK_TIMEOUT(LT),
      .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
      .mode_sel(mode_sel), .write_from_rom(write_from_rom), .reconfig(reconfig),
      .reconf_busy(reconf_busy), .pll_locked(pll_locked),
      .video_reset(video_reset), .current_mode(current_mode),
      .seq_busy(seq_busy), .done(done), .error(error), .bad_mode(bad_mode)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // altpll_reconfig model: busy for busy_len cycles after either pulse
   initial reconf_busy = 1'b0;
   always @(negedge clock) begin
      if (write_from_rom || reconfig) busy_left = busy_len;
      else if (busy_left > 0) busy_left = busy_left - 1;
      reconf_busy = (busy_left != 0);
   end

   // PLL model: loses lock on reconfig or on request, relocks after lock_delay
   initial pll_locked = 1'b0;
   always @(negedge clock) begin
      if (reconfig || (drop_tok != drop_seen)) begin
         drop_seen  = drop_tok;
         pll_locked = 1'b0;
         lock_left  = lock_delay;
      end else if (lock_left != 0) begin
         lock_left = lock_left - 1;
      end else if (lock_enable && !pll_locked) begin
         pll_locked    = 1'b1;
         lock_rise_cyc = cyc;
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         if (write_from_rom) wfr_cnt++;
         if (reconfig) rcf_cnt++;
         if (done) done_cnt++;
         if (bad_mode) bad_cnt++;
         if (req_ready) rdy_cnt++;
         if (req_ready && seq_busy) rdy_busy++;
         if (seq_busy && !video_reset) vr_viol++;
         if ((write_from_rom && wfr_prev) || (reconfig && rcf_prev) || (done && done_prev) ||
             (bad_mode && bad_prev) || (req_ready && rdy_prev)) pulse_long++;
         if (vr_prev && !video_reset) vr_fall_cyc = cyc;
         if (!vr_prev && video_reset) vr_rise_cnt++;
      end
      vr_prev = video_reset; wfr_prev = write_from_rom; rcf_prev = reconfig;
      done_prev = done; bad_prev = bad_mode; rdy_prev = req_ready;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present a request and hold it until the one-cycle req_ready
   task automatic issue(input logic [7:0] code);
      bit got;
      @(negedge clock);
      req_valid = 1'b1;
      req_mode  = code;
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clock);
         if (req_ready) got = 1'b1;
      end
      req_valid = 1'b0;
      check("accept_seen", 32'(got), 32'd1);
   endtask

   // Wait for a completion pulse or a final error, then let the monitor catch up
   task automatic wait_end(input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clock);
         if (done || bad_mode || (error && !seq_busy)) ok = 1'b1;
      end
      check(tag, 32'(ok), 32'd1);
      repeat (2) @(negedge clock);
   endtask

   // One request scored against the outcome model: 0 bad, 1 no-op, 2 reconfigure
   task automatic run_request(input logic [7:0] code);
      int kind, s_wfr, s_rcf, s_done, s_bad, s_rdy;
      if (code >= 8'(NM)) kind = 0;
      else if ((code == model_mode) && pll_locked) kind = 1;
      else kind = 2;
      s_wfr = wfr_cnt; s_rcf = rcf_cnt; s_done = done_cnt; s_bad = bad_cnt; s_rdy = rdy_cnt;
      issue(code);
      wait_end(2000, "req_complete");
      check("ready_pulses", 32'(rdy_cnt - s_rdy), 32'd1);
      check("bad_pulses", 32'(bad_cnt - s_bad), (kind == 0) ? 32'd1 : 32'd0);
      check("done_pulses", 32'(done_cnt - s_done), (kind != 0) ? 32'd1 : 32'd0);
      check("load_pulses", 32'(wfr_cnt - s_wfr), (kind == 2) ? 32'd1 : 32'd0);
      check("reconf_pulses", 32'(rcf_cnt - s_rcf), (kind == 2) ? 32'd1 : 32'd0);
      if (kind == 2) begin
         model_mode = code;
         check("mode_sel", 32'(mode_sel), 32'(code[1:0]));
         check("video_reset_released", 32'(video_reset), 32'd0);
         // one cycle to sample the lock, then SETTLE_CYCLES of settling
         check("settle_cycles", 32'(vr_fall_cyc - lock_rise_cyc), 32'(SC + 1));
      end
      check("current_mode", 32'(current_mode), 32'(model_mode));
      check("error_clear", 32'(error), 32'd0);
      check("idle_after", 32'(seq_busy), 32'd0);
   endtask

   initial begin
      int s_wfr, s_rcf, s_done, s_rise, early;
      bit ok;
      logic [7:0] code, a, b;
      int r;

      reset_n = 1'b0; req_valid = 1'b0; req_mode = 8'd0;
      repeat (3) @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_wfr", 32'(write_from_rom), 32'd0);
      check("rst_reconfig", 32'(reconfig), 32'd0);
      check("rst_mode_sel", 32'(mode_sel), 32'd0);
      check("rst_current_mode", 32'(current_mode), 32'd0);
      check("rst_video_reset", 32'(video_reset), 32'd1);
      check("rst_seq_busy", 32'(seq_busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_bad_mode", 32'(bad_mode), 32'd0);

      // 1: boot relock releases video_reset after settling
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check("boot_wait_lock_busy", 32'(seq_busy), 32'd1);
      check("boot_video_reset", 32'(video_reset), 32'd1);
      repeat (7) @(negedge clock);
      lock_enable = 1'b1;
      wait_end(400, "boot_done");
      check("boot_done_pulses", 32'(done_cnt), 32'd1);
      check("boot_video_released", 32'(video_reset), 32'd0);
      check("boot_settle_cycles", 32'(vr_fall_cyc - lock_rise_cyc), 32'(SC + 1));
      check("boot_mode", 32'(current_mode), 32'd0);

      // 2..4: reconfigure to 480p, repeat it (no-op), then an invalid code
      busy_len = 5; lock_delay = 20;
      run_request(8'd2);
      run_request(8'd2);
      run_request(8'd7);

      // 5: lock never returns -> MAX_RETRIES attempts then sticky error
      lock_enable = 1'b0;
      s_wfr = wfr_cnt; s_rcf = rcf_cnt; s_done = done_cnt;
      issue(8'd1);
      wait_end(3000, "retry_end");
      check("retry_loads", 32'(wfr_cnt - s_wfr), 32'(MR));
      check("retry_reconfs", 32'(rcf_cnt - s_rcf), 32'(MR));
      check("retry_no_done", 32'(done_cnt - s_done), 32'd0);
      check("retry_error", 32'(error), 32'd1);
      check("retry_video_reset", 32'(video_reset), 32'd1);
      check("retry_mode_kept", 32'(current_mode), 32'(model_mode));
      lock_enable = 1'b1;
      repeat (4) @(negedge clock);
      run_request(8'd3);

      // lock lost while idle: relock and settle without reloading
      s_wfr = wfr_cnt; s_done = done_cnt; s_rise = vr_rise_cnt;
      lock_delay = 20;
      drop_tok++;
      wait_end(500, "relock_done");
      check("relock_vr_raised", 32'(vr_rise_cnt - s_rise), 32'd1);
      check("relock_no_load", 32'(wfr_cnt - s_wfr), 32'd0);
      check("relock_done", 32'(done_cnt - s_done), 32'd1);
      check("relock_video_reset", 32'(video_reset), 32'd0);
      check("relock_settle", 32'(vr_fall_cyc - lock_rise_cyc), 32'(SC + 1));
      check("relock_mode", 32'(current_mode), 32'(model_mode));

      // 6: request arriving during WAIT_LOCK stays queued until done
      a = (model_mode + 8'd1) & 8'd3;
      b = (a + 8'd1) & 8'd3;
      busy_len = 3; lock_delay = 40;
      s_wfr = wfr_cnt;
      issue(a);
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clock);
         if (reconfig) ok = 1'b1;
      end
      check("q_reached_reconf", 32'(ok), 32'd1);
      repeat (8) @(negedge clock);
      req_valid = 1'b1; req_mode = b;
      ok = 1'b0; early = 0;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clock);
         if (req_ready) early++;
         if (done) ok = 1'b1;
      end
      check("q_first_done", 32'(ok), 32'd1);
      check("q_no_early_ready", 32'(early), 32'd0);
      model_mode = a;
      check("q_first_mode", 32'(current_mode), 32'(a));
      @(negedge clock);
      check("q_accept_after_done", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      wait_end(2000, "q_second_done");
      model_mode = b;
      check("q_second_mode", 32'(current_mode), 32'(b));
      check("q_loads", 32'(wfr_cnt - s_wfr), 32'd2);

      // randomized requests against the outcome model
      for (int i = 0; i < 12; i++) begin
         busy_len   = int'($urandom_range(0, 10));
         lock_delay = busy_len + int'($urandom_range(6, 30));
         r = int'($urandom_range(0, 9));
         if (r < 3) code = model_mode;
         else if (r < 5) code = 8'($urandom_range(4, 255));
         else code = 8'($urandom_range(0, 3));
         run_request(code);
      end

      check("pulse_width", 32'(pulse_long), 32'd0);
      check("video_reset_while_busy", 32'(vr_viol), 32'd0);
      check("ready_while_busy", 32'(rdy_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
